// File: rtl/move_tick_ctrl.sv
// Snake-game move timer: run/pause/over FSM with a speed level that shortens the move period.
// Ports: clk, rst (sync, active-high); start/pause_req/game_over/eat are one-cycle input pulses;
//        move_tick is a registered one-cycle enable, level the speed level, state the FSM code.
module move_tick_ctrl #(
  parameter int unsigned BASE_PERIOD = 25_000_000,
  parameter int unsigned STEP        = 2_000_000,
  parameter int unsigned MIN_PERIOD  = 5_000_000,
  parameter int unsigned MAX_LEVEL   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause_req,
  input  logic       game_over,
  input  logic       eat,
  output logic       move_tick,
  output logic [2:0] level,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam logic [31:0] BASE_W = BASE_PERIOD;
  localparam logic [31:0] STEP_W = STEP;
  localparam logic [31:0] MIN_W  = MIN_PERIOD;
  localparam logic [2:0]  MAX_LV = 3'(MAX_LEVEL);

  state_e      state_q;
  logic [31:0] counter_q;
  logic [2:0]  level_q;
  logic [1:0]  eat_q;
  logic        move_tick_q;

  logic [31:0] dec_d;
  logic [31:0] period_d;
  logic        tick_due_d;

  // Period from the registered level. The reduction is compared against the
  // base first so the subtraction can never wrap, then floored at MIN_PERIOD.
  always_comb begin
    dec_d = 32'(level_q) * STEP_W;
    if (dec_d >= BASE_W) begin
      period_d = MIN_W;
    end else if ((BASE_W - dec_d) < MIN_W) begin
      period_d = MIN_W;
    end else begin
      period_d = BASE_W - dec_d;
    end
  end

  // ">=" rather than "==" so a level-up that shrinks the period below the
  // current count still fires on the next RUN edge instead of wrapping.
  assign tick_due_d = (counter_q >= (period_d - 32'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      level_q     <= '0;
      eat_q       <= '0;
      move_tick_q <= 1'b0;
    end else begin
      move_tick_q <= 1'b0;
      unique case (state_q)
        IDLE, OVER: begin
          counter_q <= '0;
          if (start) begin
            state_q   <= RUN;
            counter_q <= '0;
            level_q   <= '0;
            eat_q     <= '0;
          end
        end
        RUN: begin
          if (game_over) begin
            state_q   <= OVER;
            counter_q <= '0;
          end else begin
            // The timer advances on this edge even when pausing, so the
            // count carried into PAUSE already includes this RUN cycle.
            if (tick_due_d) begin
              counter_q   <= '0;
              move_tick_q <= 1'b1;
            end else begin
              counter_q <= counter_q + 32'd1;
            end
            if (pause_req) begin
              state_q <= PAUSE;
            end else if (eat) begin
              eat_q <= eat_q + 2'd1;
              if ((eat_q == 2'd3) && (level_q < MAX_LV)) begin
                level_q <= level_q + 3'd1;
              end
            end
          end
        end
        PAUSE: begin
          // Counter deliberately untouched so the period resumes where it stopped.
          if (game_over) begin
            state_q   <= OVER;
            counter_q <= '0;
          end else if (pause_req) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign move_tick = move_tick_q;
  assign level     = level_q;
  assign state     = state_q;

endmodule

// File: tb/tb_move_tick_ctrl.sv
module tb_move_tick_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause_req = 1'b0;
  logic       game_over = 1'b0;
  logic       eat = 1'b0;
  logic       move_tick;
  logic [2:0] level;
  logic [1:0] state;

  move_tick_ctrl #(
    .BASE_PERIOD(20),
    .STEP       (4),
    .MIN_PERIOD (8),
    .MAX_LEVEL  (7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pause_req(pause_req),
    .game_over(game_over),
    .eat      (eat),
    .move_tick(move_tick),
    .level    (level),
    .state    (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  // Reference model state (advanced once per driven edge)
  int m_st = 0, m_cnt = 0, m_lvl = 0, m_eat = 0;
  logic [5:0] sb_q[$];

  function automatic int per(input int lvl);
    int p;
    p = 20 - 4 * lvl;
    if (p < 8) p = 8;
    return p;
  endfunction

  // Drive one cycle of inputs, push the model's post-edge outputs, step past the edge.
  task automatic cyc(input logic r, input logic s, input logic p, input logic g, input logic e);
    int nst, ncnt, nlvl, neat, ntick;
    @(negedge clk); #1;
    rst = r; start = s; pause_req = p; game_over = g; eat = e;
    nst = m_st; ncnt = m_cnt; nlvl = m_lvl; neat = m_eat; ntick = 0;
    if (r) begin
      nst = 0; ncnt = 0; nlvl = 0; neat = 0;
    end else if ((m_st == 0 || m_st == 3) && s) begin
      nst = 1; ncnt = 0; nlvl = 0; neat = 0;
    end else if (m_st == 1 || m_st == 2) begin
      if (g) begin
        nst = 3; ncnt = 0;
      end else if (m_st == 2) begin
        if (p) nst = 1;
      end else begin
        if (m_cnt >= per(m_lvl) - 1) begin ncnt = 0; ntick = 1; end
        else ncnt = m_cnt + 1;
        if (p) nst = 2;
        else if (e) begin
          if (m_eat == 3) begin
            neat = 0;
            if (m_lvl < 7) nlvl = m_lvl + 1;
          end else neat = m_eat + 1;
        end
      end
    end
    m_st = nst; m_cnt = ncnt; m_lvl = nlvl; m_eat = neat;
    sb_q.push_back({ntick[0], nlvl[2:0], nst[1:0]});
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; pause_req = 1'b0; game_over = 1'b0; eat = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [5:0] exp;
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      chk("scoreboard{tick,level,state}", {26'd0, move_tick, level, state}, {26'd0, exp});
    end
  end

  // Idle cycles until move_tick is seen; n = edges taken, max+1 on timeout.
  task automatic idle_until_tick(input int max, output int n);
    n = 0;
    while (n <= max) begin
      cyc(0, 0, 0, 0, 0);
      n++;
      if (move_tick) return;
    end
  endtask

  typedef struct {
    logic r, s, p, g, e;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[18];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    vecs[0]  = '{1, 0, 0, 0, 0, 2'd0};  // reset
    vecs[1]  = '{0, 0, 1, 0, 0, 2'd0};  // pause ignored in IDLE
    vecs[2]  = '{0, 0, 0, 0, 1, 2'd0};  // eat ignored in IDLE
    vecs[3]  = '{0, 0, 0, 1, 0, 2'd0};  // game_over ignored in IDLE
    vecs[4]  = '{0, 1, 0, 0, 0, 2'd1};  // start -> RUN
    vecs[5]  = '{0, 1, 0, 0, 0, 2'd1};  // start ignored in RUN
    vecs[6]  = '{0, 0, 1, 0, 0, 2'd2};  // pause
    vecs[7]  = '{0, 0, 0, 0, 1, 2'd2};  // eat in PAUSE
    vecs[8]  = '{0, 1, 0, 0, 0, 2'd2};  // start ignored in PAUSE
    vecs[9]  = '{0, 0, 1, 0, 0, 2'd1};  // resume
    vecs[10] = '{0, 0, 1, 1, 0, 2'd3};  // game_over beats pause
    vecs[11] = '{0, 0, 1, 0, 0, 2'd3};  // pause ignored in OVER
    vecs[12] = '{0, 0, 0, 0, 1, 2'd3};  // eat ignored in OVER
    vecs[13] = '{0, 1, 0, 0, 0, 2'd1};  // restart
    vecs[14] = '{0, 0, 1, 0, 0, 2'd2};
    vecs[15] = '{0, 0, 0, 1, 0, 2'd3};  // game_over from PAUSE
    vecs[16] = '{0, 1, 0, 1, 0, 2'd1};  // OVER: start wins, game_over ignored
    vecs[17] = '{1, 1, 0, 0, 0, 2'd0};  // rst overrides start

    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].g, vecs[i].e);
      chk($sformatf("fsm_vec%0d_state", i), {30'd0, state}, {30'd0, vecs[i].st});
    end

    // Reset state
    cyc(1, 0, 0, 0, 0);
    chk("reset_state", {30'd0, state}, 0);
    chk("reset_level", {29'd0, level}, 0);
    chk("reset_tick", {31'd0, move_tick}, 0);

    // Base timing: first tick 20 edges after start, then every 20, one cycle wide
    cyc(0, 1, 0, 0, 0);
    chk("start_state", {30'd0, state}, 1);
    idle_until_tick(64, n); chk("first_tick_latency", n, 20);
    cyc(0, 0, 0, 0, 0);     chk("tick_width", {31'd0, move_tick}, 0);
    idle_until_tick(64, n); chk("tick_spacing_l0_b", n, 19);
    idle_until_tick(64, n); chk("tick_spacing_l0_c", n, 20);

    // Level-up and period clamp
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    chk("level_after_4_eats", {29'd0, level}, 1);
    idle_until_tick(64, n);
    idle_until_tick(64, n); chk("tick_spacing_l1", n, 16);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 1);
    chk("level_after_16_eats", {29'd0, level}, 4);
    idle_until_tick(64, n);
    idle_until_tick(64, n); chk("tick_spacing_l4_clamped", n, 8);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1);
    chk("level_saturated", {29'd0, level}, 7);
    idle_until_tick(64, n);
    idle_until_tick(64, n); chk("tick_spacing_l7", n, 8);

    // game_over during a tick cycle: tick visible now, OVER next, no more ticks
    chk("tick_before_game_over", {31'd0, move_tick}, 1);
    cyc(0, 0, 0, 1, 0);
    chk("game_over_state", {30'd0, state}, 3);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin cyc(0, 0, 0, 0, 0); cnt += move_tick; end
    chk("ticks_in_over", cnt, 0);

    // Pause 5 cycles after a tick, hold 100 cycles, resume -> tick 15 later
    cyc(0, 1, 0, 0, 0);
    chk("restart_level", {29'd0, level}, 0);
    idle_until_tick(64, n); chk("restart_first_tick", n, 20);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("paused_state", {30'd0, state}, 2);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin cyc(0, 0, 0, 0, 0); cnt += move_tick; end
    chk("ticks_in_pause", cnt, 0);
    cyc(0, 0, 1, 0, 0);
    chk("resumed_state", {30'd0, state}, 1);
    idle_until_tick(64, n); chk("resume_to_tick", n, 15);

    // game_over + pause together -> OVER; restart from OVER
    cyc(0, 0, 1, 1, 0);
    chk("go_and_pause_state", {30'd0, state}, 3);
    cyc(0, 1, 0, 0, 0);
    chk("over_restart_state", {30'd0, state}, 1);
    idle_until_tick(64, n); chk("over_restart_first_tick", n, 20);

    // Level-up mid-period with count already past the new period
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("midperiod_level", {29'd0, level}, 1);
    chk("midperiod_no_tick_yet", {31'd0, move_tick}, 0);
    cyc(0, 0, 0, 0, 0);
    chk("midperiod_immediate_tick", {31'd0, move_tick}, 1);
    idle_until_tick(64, n); chk("midperiod_next_spacing", n, 16);

    // Reset while paused at level 3; IDLE ignores eat/pause
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    chk("pre_reset_level", {29'd0, level}, 3);
    chk("pre_reset_state", {30'd0, state}, 2);
    cyc(1, 0, 0, 0, 0);
    chk("rst_in_pause_outputs", {26'd0, move_tick, level, state}, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    chk("idle_ignores_inputs", {26'd0, move_tick, level, state}, 0);

    @(negedge clk); #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_tick_ctrl.md
MOVE_TICK_CTRL -- requirements
Module: move_tick_ctrl

Interface
REQ-001 Parameter BASE_PERIOD, default 25_000_000: clk cycles per move at level 0.
REQ-002 Parameter STEP, default 2_000_000: period reduction per level.
REQ-003 Parameter MIN_PERIOD, default 5_000_000: floor on the move period.
REQ-004 Parameter MAX_LEVEL, default 7: saturation value of level; must be ≤7.
REQ-005 Port list:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  pulse; begins or restarts a game.
- pause_req  in  1  pulse; toggles run/pause.
- game_over  in  1  pulse; collision detected.
- eat  in  1  pulse; food eaten.
- move_tick  out  1  one-cycle enable; snake advances one cell.
- level  out  3  current speed level.
- state  out  2  FSM state encoding.
REQ-006 One clock only; all outputs registered; no derived clocks, no gated clocks.

Function
REQ-007 FSM states: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, OVER=2'd3.
REQ-008 IDLE: start → RUN; all other inputs ignored.
REQ-009 RUN: game_over → OVER; else pause_req → PAUSE; else remain.
REQ-010 PAUSE: game_over → OVER; else pause_req → RUN; else remain.
REQ-011 OVER: start → RUN; all other inputs ignored.
REQ-012 Input priority in one cycle: game_over > pause_req > eat; start is acted on only in IDLE or OVER.
REQ-013 On any transition into RUN from IDLE or OVER: cycle counter = 0, level = 0, eat counter = 0 on the next edge.
REQ-014 Period = max(BASE_PERIOD − level×STEP, MIN_PERIOD), computed from registered level, 32-bit unsigned with no underflow; clamp before subtract wraps.
REQ-015 Cycle counter, 32-bit: increments only in RUN.
- In RUN, when counter ≥ period−1: move_tick=1 for exactly that cycle, counter → 0.
- Otherwise move_tick=0.
REQ-016 Counter holds its value in PAUSE; on resume, counting continues with no tick lost or duplicated.
REQ-017 Counter and move_tick are 0 in IDLE and OVER.
REQ-018 Eat counter, 2-bit: eat in RUN increments it (no priority winner above eat needed besides REQ-012). On 3→0 wrap, level increments, saturating at MAX_LEVEL. Eat ignored outside RUN.
REQ-019 Level increase mid-period: the new period applies immediately. If counter ≥ new period−1, move_tick fires on the next RUN cycle.
REQ-020 Latency: start sampled at edge t in IDLE → state=RUN after t; first move_tick asserted period cycles after t.
REQ-021 game_over in the same cycle as move_tick: move_tick for that cycle is still asserted; state=OVER next cycle; no further ticks.

Reset
REQ-022 rst sampled high at a clk edge: state=IDLE, counter=0, eat counter=0, level=0, move_tick=0. rst overrides all other inputs, including mid-game and mid-tick.
REQ-023 Power-up values are irrelevant; rst must be asserted ≥1 cycle before use.

Verification (BASE_PERIOD=20, STEP=4, MIN_PERIOD=8, MAX_LEVEL=7)
REQ-024 Reset then start pulse at cycle 0 → state=1 from cycle 1; move_tick at cycles 20, 40, 60, each 1 cycle wide.
REQ-025 In RUN: 4 eat pulses → level=1, tick spacing 16. 12 further eats → level=4, spacing 8 (clamped). 16 further eats → level=7, saturating; spacing stays 8.
REQ-026 pause_req 5 cycles after a tick → state=2, no ticks for 100 cycles. pause_req again → next tick exactly 15 cycles after the resume edge.
REQ-027 game_over and pause_req in the same RUN cycle → state=3 next cycle; no ticks. start → state=1, level=0, first tick after 20 cycles.
REQ-028 Level 0 with counter=17, 4th eat → level=1. Period becomes 16; counter 17 ≥ 15, so tick on the next cycle and counter → 0.
REQ-029 rst asserted in PAUSE at level 3 → all outputs 0 and state=0 next cycle. eat and pause_req in IDLE have no effect.
